// File: rtl/demux1hot_buf.sv
// Steers one word to a one-hot-selected lane, each backed by a 2-entry FIFO; 1-cycle latency.
// Backpressure: in_ready drops only when the selected lane is full; bad selects are always accepted and dropped.

module demux1hot_fifo2 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             vld,
  output logic             full,
  output logic [WIDTH-1:0] dat
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  // Gate locally so a stray request can never corrupt the count.
  assign do_push = push && !full;
  assign do_pop  = pop && vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign vld  = (cnt != 2'd0);
  assign full = (cnt == 2'd2);
  assign dat  = vld ? mem[rd_ptr] : '0;
endmodule

module demux1hot_buf #(
  parameter int WIDTH   = 3,
  parameter int OUTPUTS = 3,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [OUTPUTS-1:0]         in_sel,
  output logic [OUTPUTS-1:0]         out_valid,
  input  logic [OUTPUTS-1:0]         out_ready,
  output logic [OUTPUTS*WIDTH-1:0]   out_data,
  output logic                       sel_err,
  output logic [CNT_W-1:0]           err_count
);
  logic               onehot;
  logic               accept;
  logic [OUTPUTS-1:0] full;
  logic [OUTPUTS-1:0] push;

  assign onehot   = (in_sel != '0) && ((in_sel & (in_sel - OUTPUTS'(1))) == '0);
  // With a one-hot select, masking by full isolates the chosen lane.
  assign in_ready = onehot ? ((in_sel & full) == '0) : 1'b1;
  assign accept   = in_valid && in_ready;
  assign push     = (accept && onehot) ? in_sel : '0;

  for (genvar i = 0; i < OUTPUTS; i++) begin : g_lane
    demux1hot_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[i]),
      .push_dat (in_data),
      .pop      (out_ready[i]),
      .vld      (out_valid[i]),
      .full     (full[i]),
      .dat      (out_data[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else if (accept && !onehot) begin
      sel_err <= 1'b1;
      if (err_count != '1) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_demux1hot_buf.sv
// Scoreboard bench: driver models acceptance and queues expected words; monitor checks lane heads each cycle.
module tb_demux1hot_buf;
  localparam int W = 3;
  localparam int N = 3;
  localparam int C = 8;
  localparam int SAT = (1 << C) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [N-1:0]   in_sel = '0;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '0;
  logic [N*W-1:0] out_data;
  logic           sel_err;
  logic [C-1:0]   err_count;

  demux1hot_buf #(.WIDTH(W), .OUTPUTS(N), .CNT_W(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q [N][$];
  bit           exp_err = 1'b0;
  int           exp_cnt = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One producer/consumer cycle; the expected effect lands in the model at the clock edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic [N-1:0] s, input logic [N-1:0] r);
    bit oh;
    bit rdy;
    int lane;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = r;
    #1;
    oh   = ($countones(s) == 1);
    lane = 0;
    for (int i = 0; i < N; i++) if (s[i]) lane = i;
    rdy = oh ? (exp_q[lane].size() < 2) : 1'b1;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (v && rdy && reset) begin
      if (oh) exp_q[lane].push_back(d);
      else begin
        exp_err = 1'b1;
        if (exp_cnt < SAT) exp_cnt++;
      end
    end
  endtask

  // Monitor: compare every lane head, then retire the word the consumer takes.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        bit           ev;
        logic [W-1:0] ed;
        ev = (exp_q[i].size() != 0);
        ed = ev ? exp_q[i][0] : '0;
        check($sformatf("lane%0d_valid", i), {31'd0, out_valid[i]}, {31'd0, ev});
        check($sformatf("lane%0d_data", i), {29'd0, out_data[i*W +: W]}, {29'd0, ed});
        if (ev && out_ready[i] && reset) void'(exp_q[i].pop_front());
      end
      check("sel_err", {31'd0, sel_err}, {31'd0, exp_err});
      check("err_count", {24'd0, err_count}, exp_cnt);
    end
  end

  initial begin
    int rsel;
    logic [N-1:0] s;
    #1;
    check("rst_out_valid", {29'd0, out_valid}, 0);
    check("rst_out_data", {23'd0, out_data}, 0);
    check("rst_sel_err", {31'd0, sel_err}, 0);
    check("rst_err_count", {24'd0, err_count}, 0);
    #12 reset = 1'b1;

    // basic routing
    drive(1'b1, 3'b101, 3'b010, 3'b111);
    drive(1'b0, 3'b000, 3'b000, 3'b111);
    drive(1'b0, 3'b000, 3'b000, 3'b111);
    // lane 0 fills, third word stalls, lane 2 stays open
    drive(1'b1, 3'b001, 3'b001, 3'b000);
    drive(1'b1, 3'b010, 3'b001, 3'b000);
    drive(1'b1, 3'b011, 3'b001, 3'b000);
    drive(1'b1, 3'b111, 3'b100, 3'b000);
    drive(1'b1, 3'b011, 3'b001, 3'b001);
    drive(1'b1, 3'b011, 3'b001, 3'b001);
    drive(1'b0, 3'b000, 3'b000, 3'b111);
    drive(1'b0, 3'b000, 3'b000, 3'b111);
    // push and pop together at count 1
    drive(1'b1, 3'b100, 3'b010, 3'b000);
    drive(1'b1, 3'b110, 3'b010, 3'b010);
    drive(1'b0, 3'b000, 3'b000, 3'b010);
    // bad selects
    drive(1'b1, 3'b111, 3'b000, 3'b000);
    drive(1'b1, 3'b111, 3'b011, 3'b000);
    drive(1'b0, 3'b000, 3'b000, 3'b000);

    // asynchronous reset between edges with lane 2 loaded
    drive(1'b1, 3'b101, 3'b100, 3'b000);
    drive(1'b1, 3'b110, 3'b100, 3'b000);
    in_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("arst_out_valid", {29'd0, out_valid}, 0);
    check("arst_out_data", {23'd0, out_data}, 0);
    check("arst_sel_err", {31'd0, sel_err}, 0);
    check("arst_err_count", {24'd0, err_count}, 0);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    exp_err = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    #3 reset = 1'b1;

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      rsel = $urandom_range(0, 9);
      if (rsel < 8) s = N'(1) << $urandom_range(0, N - 1);
      else s = N'($urandom);
      drive(($urandom_range(0, 3) != 0), W'($urandom), s, N'($urandom));
    end

    // drive the error counter into saturation
    for (int k = 0; k < SAT + 10; k++) drive(1'b1, 3'b000, 3'b000, 3'b111);
    drive(1'b0, 3'b000, 3'b000, 3'b111);
    #3;
    check("err_count_sat", {24'd0, err_count}, SAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux1hot_buf.md
Name: demux1hot_buf

Overview:
- Inverse of the 1-hot mux: steers one input word to exactly one of OUTPUTS lanes, selected by a one-hot vector.
- Each lane has a 2-entry FIFO and a valid/ready handshake, so slow consumers on one lane do not stall the others once that lane's word is accepted.
- Sits between a single producer and OUTPUTS consumers.
- Output data is flattened the same way as the mux input bus: lane i occupies bits [i*WIDTH +: WIDTH].

Parameters:
- WIDTH, 3, data bits per word.
- OUTPUTS, 3, number of output lanes. Must be >= 2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; asserted when low.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  word to route.
- in_sel  in  OUTPUTS  one-hot destination lane; sampled with in_data.
- out_valid  out  OUTPUTS  bit i: lane i head entry is valid.
- out_ready  in  OUTPUTS  bit i: consumer i takes lane i head.
- out_data  out  OUTPUTS*WIDTH  lane i head at [i*WIDTH +: WIDTH].
- sel_err  out  1  sticky flag: a non-one-hot in_sel was accepted.
- err_count  out  CNT_W  count of dropped words; saturates at all-ones.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release on next edge):
  - all lane counts = 0
  - out_valid = 0
  - out_data = 0
  - sel_err = 0
  - err_count = 0
  - storage contents are don't-care, but out_data reads 0 while the lane is empty.
- onehot = (in_sel != 0) && ((in_sel & (in_sel - 1)) == 0).
- in_ready (combinational from in_sel and lane counts; never from out_ready):
  - onehot: in_ready = 1 iff the selected lane count < 2.
  - not onehot: in_ready = 1 (word is accepted and dropped).
- Accept = in_valid && in_ready.
  - onehot: push in_data into the selected lane.
  - not onehot: no push; set sel_err = 1; increment err_count if it is below 2^CNT_W-1.
- Lane i FIFO, 2 entries:
  - Pop = out_valid[i] && out_ready[i].
  - out_valid[i] = (count_i != 0).
  - Lane i slice of out_data = head entry, or 0 when empty.
- Latency: a word accepted at posedge k is visible on out_valid/out_data after posedge k (one cycle). There is no combinational in-to-out path.
- Simultaneous push and pop on the same lane:
  - count 1: count stays 1; new word becomes head after the old one pops.
  - count 2: push is impossible (in_ready = 0); pop only.
  - count 0: push only; there is no bypass.
- Ordering: FIFO order is preserved per lane. There is no ordering relation across lanes.
- Lanes are independent: a pop on lane j and a push on lane i happen in the same cycle without interaction.
- out_ready on an empty lane is ignored.
- in_sel / in_data may change freely while in_valid = 0. When in_valid = 1 and in_ready = 0, the producer holds them stable; the block does not check this.
- sel_err clears only by reset.
- err_count stays at saturation and never wraps.
- Reset mid-operation: all buffered words are discarded and the block returns immediately to the reset values.

Test Plan (WIDTH=3, OUTPUTS=3):
- Basic routing:
  - Stimulus: after reset, send in_data=3'b101 with in_sel=3'b010, all out_ready=1.
  - Response: next cycle out_valid=3'b010 and out_data[5:3]=3'b101. Lanes 0 and 2 read 0. Lane empties the cycle after.
- Lane full:
  - Stimulus: out_ready=0; send 3'b001, 3'b010, then 3'b011, all with in_sel=3'b001.
  - Response: first two accepted. in_ready=0 for the third while the lane holds 2. Raise out_ready[0]: pops 001, then 010 in order. Third word is accepted on the cycle count drops to 1.
- Cross-lane independence:
  - Stimulus: lane 0 full and stalled; send 3'b111 with in_sel=3'b100.
  - Response: in_ready=1 and accepted. out_valid=3'b101.
- Push+pop at count 1:
  - Stimulus: lane 1 holds 3'b100 with out_ready[1]=1; push 3'b110 with in_sel=3'b010 the same cycle.
  - Response: count stays 1; next head is 3'b110.
- Bad select:
  - Stimulus: in_sel=3'b000, then 3'b011, each with in_valid=1.
  - Response: both accepted with in_ready=1; no lane changes; sel_err=1; err_count=2. With CNT_W=2, 5 bad words give err_count=3.
- Async reset:
  - Stimulus: load 2 words into lane 2; drive reset low between clock edges.
  - Response: out_valid=0, out_data=0, sel_err=0, err_count=0 immediately, without waiting for a clock edge.
